// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: turns pc fetch requests into timed reads of the base
// instruction SRAM and returns each word with a one-cycle valid strobe.
module inst_fetch_responder #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          ADDR_W      = 20,
  parameter logic [31:0] BASE_ADDR   = 32'h80000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ce,
  input  logic [31:0]       req_addr,
  input  logic              flush,
  input  logic [31:0]       sram_data_in,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output logic              stall_pc,
  output logic [31:0]       inst,
  output logic [31:0]       inst_addr_out,
  output logic              inst_valid,
  output logic              addr_err
);

  localparam int             CNT_W        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [32:0]    WINDOW_BYTES = 33'd4 << ADDR_W;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_reg;
  logic [31:0]      offset;
  logic             addr_ok;
  logic             accept;
  logic             cnt_zero;

  // Window check is done on the wrapped offset, so BASE_ADDR <= addr < BASE_ADDR+size
  // collapses to a single unsigned compare.
  assign offset   = req_addr - BASE_ADDR;
  assign addr_ok  = (req_addr[1:0] == 2'b00) && ({1'b0, offset} < WINDOW_BYTES);
  assign accept   = req_ce && !flush;
  assign cnt_zero = (cnt == '0);

  // Stall drops in the last access cycle so pc advances on the same edge the data lands.
  assign stall_pc = rst && (((state == IDLE) && accept && addr_ok) ||
                            ((state == ACCESS) && !cnt_zero && !flush));

  assign sram_we_n = 1'b1;

  // NOTE: reset here is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      a_reg         <= BASE_ADDR;
      inst          <= '0;
      inst_addr_out <= BASE_ADDR;
      inst_valid    <= 1'b0;
      addr_err      <= 1'b0;
      sram_addr     <= '0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_be_n     <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments throughout; the strobes default low and are raised only on completion.
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (addr_ok) begin
              a_reg     <= req_addr;
              sram_addr <= offset[ADDR_W+1:2];
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              sram_be_n <= 4'h0;
              cnt       <= CNT_LOAD;
              state     <= ACCESS;
            end else begin
              // Bad fetches return a nop tagged with the offending address, no SRAM cycle.
              inst          <= '0;
              inst_addr_out <= req_addr;
              inst_valid    <= 1'b1;
              addr_err      <= 1'b1;
            end
          end
        end

        ACCESS: begin
          if (flush) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= 4'hF;
            cnt       <= '0;
            state     <= IDLE;
          end else if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            inst          <= sram_data_in;
            inst_addr_out <= a_reg;
            inst_valid    <= 1'b1;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_be_n     <= 4'hF;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder (WAIT_CYCLES=2): inputs change 1 ns after each
// rising edge, registered outputs are read then, stall_pc is read after the inputs settle.
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ce;
  logic [31:0] req_addr;
  logic        flush;
  logic [31:0] sram_data_in;
  logic [19:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;
  logic        stall_pc;
  logic [31:0] inst;
  logic [31:0] inst_addr_out;
  logic        inst_valid;
  logic        addr_err;

  logic        use_model;
  logic [31:0] sram_data;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  // Simple SRAM model: word at index k reads back as 32'hABC00000 | k.
  assign sram_data_in = use_model ? (32'hABC00000 | 32'(sram_addr)) : sram_data;

  always #5 clk = ~clk;

  inst_fetch_responder #(
    .WAIT_CYCLES(2),
    .ADDR_W     (20),
    .BASE_ADDR  (32'h80000000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_ce       (req_ce),
    .req_addr     (req_addr),
    .flush        (flush),
    .sram_data_in (sram_data_in),
    .sram_addr    (sram_addr),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_be_n    (sram_be_n),
    .stall_pc     (stall_pc),
    .inst         (inst),
    .inst_addr_out(inst_addr_out),
    .inst_valid   (inst_valid),
    .addr_err     (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    req_ce    = 1'b1;
    req_addr  = 32'h80000010;
    flush     = 1'b0;
    use_model = 1'b0;
    sram_data = 32'hDEADBEEF;
    pc        = 32'h80000000;

    // 1: reset held two cycles with a request offered
    tick();
    #1 check("rst_stall_c1", 32'(stall_pc), 32'd0);
    tick();
    #1 check("rst_stall_c2", 32'(stall_pc), 32'd0);
    check("rst_inst",       inst,              32'h0);
    check("rst_inst_addr",  inst_addr_out,     32'h80000000);
    check("rst_valid",      32'(inst_valid),   32'd0);
    check("rst_addr_err",   32'(addr_err),     32'd0);
    check("rst_sram_addr",  32'(sram_addr),    32'd0);
    check("rst_ce_n",       32'(sram_ce_n),    32'd1);
    check("rst_oe_n",       32'(sram_oe_n),    32'd1);
    check("rst_we_n",       32'(sram_we_n),    32'd1);
    check("rst_be_n",       32'(sram_be_n),    32'hF);
    req_ce = 1'b0;
    rst    = 1'b1;
    tick();

    // 2: single fetch of 80000010
    req_ce   = 1'b1;
    req_addr = 32'h80000010;
    #1 check("single_stall_T", 32'(stall_pc), 32'd1);
    tick();
    req_ce = 1'b0;
    #1 check("single_stall_T1", 32'(stall_pc), 32'd1);
    check("single_sram_addr_T1", 32'(sram_addr), 32'd4);
    check("single_ce_n_T1",      32'(sram_ce_n), 32'd0);
    check("single_oe_n_T1",      32'(sram_oe_n), 32'd0);
    check("single_be_n_T1",      32'(sram_be_n), 32'h0);
    check("single_valid_T1",     32'(inst_valid), 32'd0);
    tick();
    sram_data = 32'h24020001;
    #1 check("single_stall_T2", 32'(stall_pc), 32'd0);
    check("single_sram_addr_T2", 32'(sram_addr), 32'd4);
    tick();
    check("single_inst",      inst,            32'h24020001);
    check("single_inst_addr", inst_addr_out,   32'h80000010);
    check("single_valid_T3",  32'(inst_valid), 32'd1);
    check("single_err_T3",    32'(addr_err),   32'd0);
    check("single_ce_n_T3",   32'(sram_ce_n),  32'd1);
    check("single_be_n_T3",   32'(sram_be_n),  32'hF);
    tick();
    check("single_valid_T4", 32'(inst_valid), 32'd0);
    check("single_hold_T4",  inst,            32'h24020001);

    // 3: back-to-back fetches driven by a pc that advances when not stalled
    use_model = 1'b1;
    pc        = 32'h80000000;
    for (int i = 0; i <= 12; i++) begin
      if (i >= 3 && (i % 3) == 0) begin
        check("b2b_valid",     32'(inst_valid), 32'd1);
        check("b2b_inst_addr", inst_addr_out,   32'h80000000 + 32'(4 * (i / 3 - 1)));
        check("b2b_inst",      inst,            32'hABC00000 + 32'(i / 3 - 1));
      end else begin
        check("b2b_no_valid", 32'(inst_valid), 32'd0);
      end
      req_ce   = (i < 10);
      req_addr = pc;
      #1 check("b2b_stall", 32'(stall_pc), 32'((i < 12) && ((i % 3) != 2)));
      if (!stall_pc) pc = pc + 32'd4;
      tick();
    end
    use_model = 1'b0;
    req_ce    = 1'b0;
    tick();

    // 4: flush one cycle after accept
    req_ce   = 1'b1;
    req_addr = 32'h80000020;
    #1 check("flush_stall_T", 32'(stall_pc), 32'd1);
    tick();
    req_ce = 1'b0;
    flush  = 1'b1;
    #1 check("flush_stall_T1", 32'(stall_pc), 32'd0);
    check("flush_ce_n_T1", 32'(sram_ce_n), 32'd0);
    tick();
    flush = 1'b0;
    check("flush_ce_n_T2",  32'(sram_ce_n),  32'd1);
    check("flush_oe_n_T2",  32'(sram_oe_n),  32'd1);
    check("flush_valid_T2", 32'(inst_valid), 32'd0);
    req_ce   = 1'b1;
    req_addr = 32'h80000030;
    #1 check("flush_reaccept_stall", 32'(stall_pc), 32'd1);
    tick();
    req_ce = 1'b0;
    check("flush_valid_T3",     32'(inst_valid), 32'd0);
    check("flush_ce_n_T3",      32'(sram_ce_n),  32'd0);
    check("flush_sram_addr_T3", 32'(sram_addr),  32'hC);
    sram_data = 32'h11112222;
    tick();
    check("flush_valid_T4", 32'(inst_valid), 32'd0);
    tick();
    check("flush_after_valid", 32'(inst_valid), 32'd1);
    check("flush_after_addr",  inst_addr_out,   32'h80000030);
    check("flush_after_inst",  inst,            32'h11112222);

    // 5: misaligned, below window, just past window, then the last legal word
    req_ce   = 1'b1;
    req_addr = 32'h80000002;
    #1 check("bad_misal_stall", 32'(stall_pc), 32'd0);
    tick();
    check("bad_misal_valid", 32'(inst_valid), 32'd1);
    check("bad_misal_err",   32'(addr_err),   32'd1);
    check("bad_misal_inst",  inst,            32'h0);
    check("bad_misal_addr",  inst_addr_out,   32'h80000002);
    check("bad_misal_ce_n",  32'(sram_ce_n),  32'd1);
    req_addr = 32'h00001000;
    #1 check("bad_low_stall", 32'(stall_pc), 32'd0);
    tick();
    check("bad_low_valid", 32'(inst_valid), 32'd1);
    check("bad_low_err",   32'(addr_err),   32'd1);
    check("bad_low_addr",  inst_addr_out,   32'h00001000);
    check("bad_low_ce_n",  32'(sram_ce_n),  32'd1);
    req_addr = 32'h80400000;
    #1 check("bad_high_stall", 32'(stall_pc), 32'd0);
    tick();
    check("bad_high_err",  32'(addr_err),  32'd1);
    check("bad_high_addr", inst_addr_out,  32'h80400000);
    req_addr = 32'h803FFFFC;
    #1 check("top_stall", 32'(stall_pc), 32'd1);
    tick();
    req_ce = 1'b0;
    check("top_err_clear",  32'(addr_err),  32'd0);
    check("top_sram_addr",  32'(sram_addr), 32'hFFFFF);
    check("top_ce_n",       32'(sram_ce_n), 32'd0);
    sram_data = 32'h0BADF00D;
    tick();
    tick();
    check("top_valid", 32'(inst_valid), 32'd1);
    check("top_err",   32'(addr_err),   32'd0);
    check("top_addr",  inst_addr_out,   32'h803FFFFC);
    check("top_inst",  inst,            32'h0BADF00D);

    // 6: reset asserted one cycle after accept
    req_ce   = 1'b1;
    req_addr = 32'h80000040;
    tick();
    req_ce = 1'b0;
    rst    = 1'b0;
    #1 check("rstmid_stall", 32'(stall_pc), 32'd0);
    tick();
    check("rstmid_ce_n",  32'(sram_ce_n),  32'd1);
    check("rstmid_valid", 32'(inst_valid), 32'd0);
    check("rstmid_addr",  inst_addr_out,   32'h80000000);
    rst = 1'b1;
    tick();
    check("rstmid_valid_after", 32'(inst_valid), 32'd0);
    req_ce   = 1'b1;
    req_addr = 32'h80000044;
    #1 check("rstmid_idle_accept", 32'(stall_pc), 32'd1);
    tick();
    req_ce = 1'b0;
    check("rstmid_new_sram_addr", 32'(sram_addr), 32'h11);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
